// File: rtl/fir_frame_streamer.sv
// Streams one frame to a FIR core: the coefficient bank first, then buffered samples up to the
// sample flagged last, then LENGTH-1 zero pads and a stop pulse. Every output is a flop.
module fir_frame_streamer #(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         coeffWrite,
    input  logic signed [DATA_WIDTH-1:0] coeffData,
    input  logic                         sampleWrite,
    input  logic signed [DATA_WIDTH-1:0] sampleData,
    input  logic                         sampleLast,
    input  logic                         start,
    output logic                         sampleFull,
    output logic                         coeffSetFlag,
    output logic signed [DATA_WIDTH-1:0] coeffIn,
    output logic                         loadDataFlag,
    output logic signed [DATA_WIDTH-1:0] dataIn,
    output logic                         stopDataLoadFlag,
    output logic                         busy,
    output logic                         frameDone,
    output logic                         underrun
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, COEFF, LOAD, PAD, STOP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   coeff_bank_q [LENGTH];
    logic [DATA_WIDTH-1:0]   coeff_bank_d [LENGTH];
    logic [CW-1:0]           coeff_wr_idx_q, coeff_wr_idx_d;
    logic [CW-1:0]           coeff_rd_idx_q, coeff_rd_idx_d;
    logic [CW-1:0]           pad_cnt_q, pad_cnt_d;

    logic [DATA_WIDTH:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             fifo_cnt_q, fifo_cnt_d;
    logic                    fifo_push, fifo_pop, fifo_empty;
    logic [DATA_WIDTH:0]     fifo_head;

    logic                    full_q, full_d;
    logic                    coeff_flag_q, coeff_flag_d;
    logic [DATA_WIDTH-1:0]   coeff_q, coeff_d;
    logic                    load_flag_q, load_flag_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    stop_flag_q, stop_flag_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    underrun_q, underrun_d;

    // Outputs are computed one cycle ahead: each state decides what the FIR sees next cycle.
    always_comb begin
        state_d        = state_q;
        coeff_bank_d   = coeff_bank_q;
        coeff_wr_idx_d = coeff_wr_idx_q;
        coeff_rd_idx_d = coeff_rd_idx_q;
        pad_cnt_d      = pad_cnt_q;
        coeff_flag_d   = 1'b0;
        coeff_d        = '0;
        load_flag_d    = 1'b0;
        data_d         = '0;
        stop_flag_d    = 1'b0;
        done_d         = 1'b0;
        underrun_d     = underrun_q;
        fifo_pop       = 1'b0;
        fifo_empty     = (fifo_cnt_q == '0);
        fifo_push      = sampleWrite && !full_q;
        fifo_head      = fifo_mem[rd_ptr_q];

        unique case (state_q)
            IDLE: begin
                if (coeffWrite) begin
                    coeff_bank_d[coeff_wr_idx_q] = coeffData;
                    coeff_wr_idx_d = (coeff_wr_idx_q == LAST_IDX) ? '0 : coeff_wr_idx_q + CW'(1);
                end
                if (start && !fifo_empty) begin
                    underrun_d     = 1'b0;
                    coeff_flag_d   = 1'b1;
                    coeff_d        = coeff_bank_q[0];
                    coeff_rd_idx_d = CW'(1);
                    state_d        = (LENGTH == 1) ? LOAD : COEFF;
                end
            end
            COEFF: begin
                coeff_flag_d   = 1'b1;
                coeff_d        = coeff_bank_q[coeff_rd_idx_q];
                coeff_rd_idx_d = coeff_rd_idx_q + CW'(1);
                if (coeff_rd_idx_q == LAST_IDX) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    load_flag_d = 1'b1;
                    data_d      = fifo_head[DATA_WIDTH-1:0];
                    if (fifo_head[DATA_WIDTH]) begin
                        pad_cnt_d = LAST_IDX;
                        state_d   = (LENGTH == 1) ? STOP : PAD;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            PAD: begin
                load_flag_d = 1'b1;
                pad_cnt_d   = pad_cnt_q - CW'(1);
                if (pad_cnt_q == CW'(1)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                stop_flag_d = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + AW'(fifo_push);
        rd_ptr_d = rd_ptr_q + AW'(fifo_pop);
        unique case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        full_d = (fifo_cnt_d == FULL_CNT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            coeff_wr_idx_q <= '0;
            coeff_rd_idx_q <= '0;
            pad_cnt_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            full_q         <= 1'b0;
            coeff_flag_q   <= 1'b0;
            coeff_q        <= '0;
            load_flag_q    <= 1'b0;
            data_q         <= '0;
            stop_flag_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                coeff_bank_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            coeff_bank_q   <= coeff_bank_d;
            coeff_wr_idx_q <= coeff_wr_idx_d;
            coeff_rd_idx_q <= coeff_rd_idx_d;
            pad_cnt_q      <= pad_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            full_q         <= full_d;
            coeff_flag_q   <= coeff_flag_d;
            coeff_q        <= coeff_d;
            load_flag_q    <= load_flag_d;
            data_q         <= data_d;
            stop_flag_q    <= stop_flag_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            underrun_q     <= underrun_d;
        end
    end

    // Sample storage needs no reset: emptiness is carried by the pointers and count.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= {sampleLast, sampleData};
        end
    end

    assign sampleFull       = full_q;
    assign coeffSetFlag     = coeff_flag_q;
    assign coeffIn          = coeff_q;
    assign loadDataFlag     = load_flag_q;
    assign dataIn           = data_q;
    assign stopDataLoadFlag = stop_flag_q;
    assign busy             = busy_q;
    assign frameDone        = done_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_fir_frame_streamer.sv
// Scoreboard bench for fir_frame_streamer: a frame-level model queues the expected FIR-side
// events when stimulus is issued; a negedge monitor pops and compares them as they appear.
module tb_fir_frame_streamer;

    localparam int L     = 20;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam logic [1:0] K_COEF = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_STOP = 2'd2;

    logic                 clock = 1'b0;
    logic                 resetN = 1'b0;
    logic                 coeffWrite = 1'b0;
    logic signed [DW-1:0] coeffData = '0;
    logic                 sampleWrite = 1'b0;
    logic signed [DW-1:0] sampleData = '0;
    logic                 sampleLast = 1'b0;
    logic                 start = 1'b0;
    logic                 sampleFull, coeffSetFlag, loadDataFlag, stopDataLoadFlag;
    logic                 busy, frameDone, underrun;
    logic signed [DW-1:0] coeffIn, dataIn;

    fir_frame_streamer #(.LENGTH(L), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .resetN(resetN),
        .coeffWrite(coeffWrite), .coeffData(coeffData),
        .sampleWrite(sampleWrite), .sampleData(sampleData), .sampleLast(sampleLast),
        .start(start), .sampleFull(sampleFull),
        .coeffSetFlag(coeffSetFlag), .coeffIn(coeffIn),
        .loadDataFlag(loadDataFlag), .dataIn(dataIn),
        .stopDataLoadFlag(stopDataLoadFlag), .busy(busy),
        .frameDone(frameDone), .underrun(underrun)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]    kind;
        logic [DW-1:0] val;
    } ev_t;

    ev_t           exp_q[$];
    logic [DW:0]   model_fifo[$];
    logic [DW-1:0] model_bank[L];
    int            model_widx = 0;
    bit            model_busy = 0;
    bit            frame_open = 0;
    bit            underrun_exp = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [DW-1:0] val, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: unexpected output kind %0d value 0x%0h, none expected (t=%0t)",
                     name, kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(kind), 32'(e.kind));
            chk(name, 32'(val), 32'(e.val));
        end
    endtask

    always @(negedge clock) begin
        if (resetN) begin
            chk("flag_exclusive", 32'(loadDataFlag & (coeffSetFlag | stopDataLoadFlag)), 32'd0);
            if (!coeffSetFlag) chk("coeffIn_zero", 32'(coeffIn), 32'd0);
            if (!loadDataFlag) chk("dataIn_zero", 32'(dataIn), 32'd0);
            if (coeffSetFlag) begin
                check_ev(K_COEF, coeffIn, "coeff");
                chk("busy_coeff", 32'(busy), 32'd1);
            end
            if (loadDataFlag) begin
                check_ev(K_DATA, dataIn, "data");
                chk("busy_data", 32'(busy), 32'd1);
            end
            if (stopDataLoadFlag || frameDone) begin
                chk("stop_done_pair", 32'({stopDataLoadFlag, frameDone}), 32'd3);
                check_ev(K_STOP, '0, "stop");
                model_busy = 0;
            end
        end
    end

    function automatic void push_data(input logic [DW-1:0] d, input logic last);
        exp_q.push_back('{kind: K_DATA, val: d});
        if (last) begin
            for (int i = 0; i < L - 1; i++) exp_q.push_back('{kind: K_DATA, val: '0});
            exp_q.push_back('{kind: K_STOP, val: '0});
            frame_open = 0;
        end
    endfunction

    // All drive tasks are entered just after a falling edge and return at the next one.
    task automatic write_coeff(input logic [DW-1:0] v);
        coeffWrite = 1'b1;
        coeffData  = v;
        if (!model_busy) begin
            model_bank[model_widx] = v;
            model_widx = (model_widx + 1) % L;
        end
        @(negedge clock);
        coeffWrite = 1'b0;
    endtask

    task automatic write_sample(input logic [DW-1:0] d, input logic last);
        sampleWrite = 1'b1;
        sampleData  = d;
        sampleLast  = last;
        if (model_fifo.size() < DEPTH) begin
            if (frame_open) push_data(d, last);
            else model_fifo.push_back({last, d});
        end
        @(negedge clock);
        sampleWrite = 1'b0;
        sampleLast  = 1'b0;
    endtask

    task automatic start_pulse();
        logic [DW:0] s;
        start = 1'b1;
        if (!model_busy && model_fifo.size() > 0) begin
            model_busy   = 1;
            underrun_exp = 0;
            frame_open   = 1;
            for (int i = 0; i < L; i++) exp_q.push_back('{kind: K_COEF, val: model_bank[i]});
            while (frame_open && model_fifo.size() > 0) begin
                s = model_fifo.pop_front();
                push_data(s[DW-1:0], s[DW]);
            end
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (model_busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (model_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: frame did not complete within 2000 cycles", name);
            model_busy = 0;
            frame_open = 0;
            exp_q.delete();
        end
        chk({name, "_events_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_underrun"}, 32'(underrun), 32'(underrun_exp));
        @(negedge clock);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_qsize(input int lim, input string name);
        int n = 0;
        while (exp_q.size() > lim && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() > lim) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expected events still pending %0d, required <= %0d", name, exp_q.size(), lim);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 32'({sampleFull, coeffSetFlag, coeffIn, loadDataFlag, dataIn,
                       stopDataLoadFlag, busy, frameDone, underrun}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lastpos, c;
        for (int i = 0; i < L; i++) model_bank[i] = '0;

        // reset state
        @(negedge clock);
        @(negedge clock);
        check_all_zero("reset_state");
        resetN = 1'b1;
        @(negedge clock);

        // basic frame: coefficients 1..20, samples 10,20,30
        for (int i = 1; i <= L; i++) write_coeff(DW'(i));
        write_sample(8'd10, 1'b0);
        write_sample(8'd20, 1'b0);
        write_sample(8'd30, 1'b1);
        start_pulse();
        c = 0;
        for (int i = 0; i < L; i++) begin
            c += int'(coeffSetFlag);
            @(negedge clock);
        end
        chk("coeff_phase_cycles", 32'(c), 32'(L));
        chk("coeff_phase_end", 32'(coeffSetFlag), 32'd0);
        wait_done("basic_frame");

        // fill to full, 65th write dropped
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("not_full_at_63", 32'(sampleFull), 32'd0);
            write_sample(DW'($urandom), i == DEPTH - 1);
        end
        chk("full_at_64", 32'(sampleFull), 32'd1);
        write_sample(8'h55, 1'b1);
        start_pulse();
        wait_done("full_frame");
        chk("full_cleared", 32'(sampleFull), 32'd0);

        // start with empty FIFO is ignored
        start_pulse();
        repeat (3) @(negedge clock);
        chk("empty_start_busy", 32'(busy), 32'd0);

        // underrun gap, start and coeffWrite ignored mid-LOAD
        write_sample(8'd10, 1'b0);
        write_sample(8'h82, 1'b0);
        start_pulse();
        wait_qsize(0, "underrun_drain");
        repeat (4) @(negedge clock);
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("gap_load_flag", 32'(loadDataFlag), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        underrun_exp = 1;
        start_pulse();
        write_coeff(8'h77);
        write_coeff(8'h66);
        repeat (3) @(negedge clock);
        write_sample(8'd120, 1'b1);
        wait_done("underrun_frame");
        write_sample(8'd5, 1'b1);
        start_pulse();
        chk("underrun_cleared", 32'(underrun), 32'd0);
        wait_done("bank_kept_frame");

        // random frames, coefficient index wrap, leftovers carried over
        for (int f = 0; f < 6; f++) begin
            if (f == 2) for (int i = 0; i < L + 5; i++) write_coeff(DW'($urandom));
            n = int'($urandom_range(1, 12));
            lastpos = int'($urandom_range(0, n - 1));
            for (int i = 0; i < n; i++) begin
                write_sample(DW'($urandom), i == lastpos);
                if ($urandom_range(0, 3) == 0) @(negedge clock);
            end
            start_pulse();
            wait_done("random_frame");
        end

        // reset during PAD aborts the frame
        for (int i = 0; i < 4; i++) write_sample(DW'($urandom), i == 3);
        start_pulse();
        wait_qsize(8, "reach_pad");
        #2;
        resetN = 1'b0;
        #1;
        check_all_zero("reset_mid_pad");
        exp_q.delete();
        model_fifo.delete();
        for (int i = 0; i < L; i++) model_bank[i] = '0;
        model_widx   = 0;
        model_busy   = 0;
        frame_open   = 0;
        underrun_exp = 0;
        repeat (3) @(negedge clock);
        check_all_zero("reset_held");
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        chk("no_stop_after_abort", 32'({stopDataLoadFlag, frameDone, busy}), 32'd0);
        write_sample(8'd33, 1'b1);
        start_pulse();
        wait_done("cleared_bank_frame");
        for (int i = 1; i <= L; i++) write_coeff(DW'(i * 3));
        write_sample(8'hF0, 1'b0);
        write_sample(8'd7, 1'b1);
        start_pulse();
        wait_done("post_reset_frame");

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
